// File: rtl/decode_issue_queue.sv
// Instruction queue between fetch and dual-issue decode: predecodes MIPS32 words
// at enqueue and presents up to ISSUE_W in-order slots. Optional counters: DIQ_PERF_EN.
module decode_issue_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ISSUE_W = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [$clog2(FETCH_W+1)-1:0]   in_count,
  input  logic [31:0]                    in_pc,
  input  logic [32*FETCH_W-1:0]          in_data,
  output logic [ISSUE_W-1:0]             out_valid,
  output logic [32*ISSUE_W-1:0]          out_pc,
  output logic [32*ISSUE_W-1:0]          out_instr,
  output logic [ISSUE_W-1:0]             out_reserved,
  output logic [ISSUE_W-1:0]             out_bd,
  input  logic [$clog2(ISSUE_W+1)-1:0]   out_accept,
  output logic [$clog2(DEPTH+1)-1:0]     count
`ifdef DIQ_PERF_EN
  ,
  output logic [31:0]                    perf_dual,
  output logic [31:0]                    perf_single
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  dst;
    logic [4:0]  src0;
    logic [4:0]  src1;
    logic        br;
    logic        mem;
    logic        hilo;
    logic        sys;
    logic        rsv;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push;

  // Field extraction and legality; an illegal word keeps only its rsv flag.
  function automatic entry_t predecode(input logic [31:0] pc, input logic [31:0] ins);
    entry_t     e;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sa;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    rd = ins[15:11]; sa = ins[10:6];  fn = ins[5:0];
    e = '0;
    e.pc = pc;
    e.instr = ins;
    case (op)
      6'h00: case (fn)
        6'h00, 6'h02, 6'h03: begin e.rsv = (rs != 5'd0); e.dst = rd; e.src1 = rt; end
        6'h04, 6'h06, 6'h07: begin e.rsv = (sa != 5'd0); e.dst = rd; e.src0 = rs; e.src1 = rt; end
        6'h08: begin e.rsv = (rt != 5'd0) || (rd != 5'd0) || (sa != 5'd0); e.br = 1'b1; e.src0 = rs; end
        6'h09: begin e.rsv = (rt != 5'd0) || (sa != 5'd0); e.br = 1'b1; e.dst = rd; e.src0 = rs; end
        6'h0C, 6'h0D: e.sys = 1'b1;
        6'h10, 6'h12: begin e.rsv = (rs != 5'd0) || (rt != 5'd0) || (sa != 5'd0); e.hilo = 1'b1; e.dst = rd; end
        6'h11, 6'h13: begin e.rsv = (rt != 5'd0) || (rd != 5'd0) || (sa != 5'd0); e.hilo = 1'b1; e.src0 = rs; end
        6'h18, 6'h19, 6'h1A, 6'h1B: begin
          e.rsv = (rd != 5'd0) || (sa != 5'd0); e.hilo = 1'b1; e.src0 = rs; e.src1 = rt;
        end
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
          e.rsv = (sa != 5'd0); e.dst = rd; e.src0 = rs; e.src1 = rt;
        end
        default: e.rsv = 1'b1;
      endcase
      6'h01: case (rt)
        5'h00, 5'h01: begin e.br = 1'b1; e.src0 = rs; end
        5'h10, 5'h11: begin e.br = 1'b1; e.src0 = rs; e.dst = 5'd31; end
        default:      e.rsv = 1'b1;
      endcase
      6'h02: e.br = 1'b1;
      6'h03: begin e.br = 1'b1; e.dst = 5'd31; end
      6'h04, 6'h05: begin e.br = 1'b1; e.src0 = rs; e.src1 = rt; end
      6'h06, 6'h07: begin e.rsv = (rt != 5'd0); e.br = 1'b1; e.src0 = rs; end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin e.dst = rt; e.src0 = rs; end
      6'h0F: begin e.rsv = (rs != 5'd0); e.dst = rt; end
      6'h10: begin
        if (ins == 32'h4200_0018) e.sys = 1'b1;
        else if (rs == 5'h00 && ins[10:3] == 8'h00) begin e.sys = 1'b1; e.dst = rt; end
        else if (rs == 5'h04 && ins[10:3] == 8'h00) begin e.sys = 1'b1; e.src1 = rt; end
        else e.rsv = 1'b1;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin e.mem = 1'b1; e.dst = rt; e.src0 = rs; end
      6'h28, 6'h29, 6'h2B: begin e.mem = 1'b1; e.src0 = rs; e.src1 = rt; end
      default: e.rsv = 1'b1;
    endcase
    if (e.rsv) begin
      e.dst = '0; e.src0 = '0; e.src1 = '0;
      e.br = 1'b0; e.mem = 1'b0; e.hilo = 1'b0; e.sys = 1'b0;
    end
    return e;
  endfunction

  assign in_ready = (CW'(DEPTH) - count_q) >= CW'(FETCH_W);
  assign push     = in_valid && in_ready;
  assign count    = count_q;

  // Pointer/occupancy update; flush discards both sides of the cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d  = tail_q + PW'(in_count);
        count_d = count_q + CW'(in_count);
      end
      head_d  = head_q + PW'(out_accept);
      count_d = count_d - CW'(out_accept);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push && !flush) begin
        for (int k = 0; k < int'(FETCH_W); k++) begin
          if (k < int'(in_count))
            mem_q[tail_q + PW'(k)] <= predecode(in_pc + 32'(4 * k), in_data[32*k +: 32]);
        end
      end
    end
  end

  assign out_valid[0]      = (count_q != '0);
  assign out_pc[31:0]      = mem_q[head_q].pc;
  assign out_instr[31:0]   = mem_q[head_q].instr;
  assign out_reserved[0]   = mem_q[head_q].rsv;
  assign out_bd[0]         = mem_q[head_q].br;

  if (ISSUE_W == 2) begin : g_pair
    logic [PW-1:0] head1;
    logic          raw, delay_slot, pair_ok;
    assign head1      = head_q + PW'(1);
    assign raw        = (mem_q[head_q].dst != 5'd0) &&
                        ((mem_q[head1].src0 == mem_q[head_q].dst) ||
                         (mem_q[head1].src1 == mem_q[head_q].dst));
    assign delay_slot = (mem_q[head1].pc == mem_q[head_q].pc + 32'd4);
    assign pair_ok    = !mem_q[head_q].sys && !mem_q[head_q].rsv && !mem_q[head_q].hilo &&
                        !mem_q[head1].br && !mem_q[head1].sys && !mem_q[head1].rsv &&
                        !mem_q[head1].hilo && !(mem_q[head_q].mem && mem_q[head1].mem) &&
                        !raw && (!mem_q[head_q].br || delay_slot);
    assign out_valid[1]    = (count_q >= CW'(2)) && pair_ok;
    assign out_pc[63:32]   = mem_q[head1].pc;
    assign out_instr[63:32] = mem_q[head1].instr;
    assign out_reserved[1] = mem_q[head1].rsv;
    assign out_bd[1]       = mem_q[head1].br;
  end

`ifdef DIQ_PERF_EN
  logic [31:0] perf_dual_q, perf_single_q;

  // Saturating issue-width counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_dual_q   <= '0;
      perf_single_q <= '0;
    end else begin
      if (ISSUE_W == 2 && 32'(out_accept) == 32'd2 && perf_dual_q != '1)
        perf_dual_q <= perf_dual_q + 32'd1;
      if (ISSUE_W == 2 && 32'(out_valid) == 32'd1 && count_q >= CW'(2) && perf_single_q != '1)
        perf_single_q <= perf_single_q + 32'd1;
    end
  end

  assign perf_dual   = perf_dual_q;
  assign perf_single = perf_single_q;
`endif

endmodule

// File: tb/tb_decode_issue_queue.sv
// Randomised bench for decode_issue_queue against a queue-of-instructions reference model.
module tb_decode_issue_queue;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned FETCH_W = 2;
  localparam int unsigned ISSUE_W = 2;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [1:0]  in_count;
  logic [31:0] in_pc;
  logic [63:0] in_data;
  logic [1:0]  out_valid, out_reserved, out_bd, out_accept;
  logic [63:0] out_pc, out_instr;
  logic [3:0]  count;
`ifdef DIQ_PERF_EN
  logic [31:0] perf_dual, perf_single;
  int unsigned pd_m, ps_m;
`endif

  always #5 clk = ~clk;

  decode_issue_queue #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_count(in_count), .in_pc(in_pc), .in_data(in_data), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr), .out_reserved(out_reserved), .out_bd(out_bd),
    .out_accept(out_accept), .count(count)
`ifdef DIQ_PERF_EN
    , .perf_dual(perf_dual), .perf_single(perf_single)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          dst, s0, s1;
    bit          br, mem, hilo, sys, rsv;
  } ins_t;

  localparam int K_ADDU = 0, K_ADDIU = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_JAL = 5, K_MULT = 6,
                 K_SYSCALL = 7, K_RSV = 8, K_SLL = 9, K_JR = 10, K_LUI = 11, K_ERET = 12, NK = 13;

  ins_t        q[$];
  ins_t        lane[2];
  int          n_tests = 0, n_fail = 0;
  logic [31:0] next_pc;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Builds an instruction of a known kind and records what it means architecturally.
  function automatic ins_t make(input int kind, input logic [31:0] pc, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm);
    ins_t i;
    i = '{pc: pc, instr: 32'h0, dst: 0, s0: 0, s1: 0, br: 0, mem: 0, hilo: 0, sys: 0, rsv: 0};
    case (kind)
      K_ADDU:    begin i.instr = {6'h00, rs, rt, rd, 5'h00, 6'h21}; i.dst = rd; i.s0 = rs; i.s1 = rt; end
      K_ADDIU:   begin i.instr = {6'h09, rs, rt, imm}; i.dst = rt; i.s0 = rs; end
      K_LW:      begin i.instr = {6'h23, rs, rt, imm}; i.dst = rt; i.s0 = rs; i.mem = 1; end
      K_SW:      begin i.instr = {6'h2B, rs, rt, imm}; i.s0 = rs; i.s1 = rt; i.mem = 1; end
      K_BEQ:     begin i.instr = {6'h04, rs, rt, imm}; i.s0 = rs; i.s1 = rt; i.br = 1; end
      K_JAL:     begin i.instr = {6'h03, rs, rt, imm}; i.dst = 31; i.br = 1; end
      K_MULT:    begin i.instr = {6'h00, rs, rt, 10'h000, 6'h18}; i.s0 = rs; i.s1 = rt; i.hilo = 1; end
      K_SYSCALL: begin i.instr = {6'h00, rs, rt, imm[9:0], 6'h0C}; i.sys = 1; end
      K_RSV:     begin i.instr = {6'h3F, rs, rt, imm}; i.rsv = 1; end
      K_SLL:     begin i.instr = {6'h00, 5'h00, rt, rd, imm[4:0], 6'h00}; i.dst = rd; i.s1 = rt; end
      K_JR:      begin i.instr = {6'h00, rs, 15'h0000, 6'h08}; i.s0 = rs; i.br = 1; end
      K_LUI:     begin i.instr = {6'h0F, 5'h00, rt, imm}; i.dst = rt; end
      default:   begin i.instr = 32'h4200_0018; i.sys = 1; end
    endcase
    return i;
  endfunction

  // Pairing rules applied to the two oldest queued instructions.
  function automatic logic [1:0] exp_valid();
    ins_t a, b;
    bit   ok;
    if (q.size() == 0) return 2'b00;
    if (q.size() == 1) return 2'b01;
    a = q[0];
    b = q[1];
    ok = !(a.sys || a.rsv || a.hilo) && !(b.br || b.sys || b.rsv || b.hilo) && !(a.mem && b.mem)
         && !(a.dst != 0 && (b.s0 == a.dst || b.s1 == a.dst)) && (!a.br || b.pc == a.pc + 32'd4);
    return ok ? 2'b11 : 2'b01;
  endfunction

  function automatic bit model_ready();
    return (int'(DEPTH) - q.size()) >= int'(FETCH_W);
  endfunction

  task automatic compare_all();
    logic [1:0] ev;
    ev = exp_valid();
    check("count", 64'(count), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'(model_ready()));
    check("out_valid", 64'(out_valid), 64'(ev));
    if (ev[0]) begin
      check("pc0", 64'(out_pc[31:0]), 64'(q[0].pc));
      check("instr0", 64'(out_instr[31:0]), 64'(q[0].instr));
      check("rsv0", 64'(out_reserved[0]), 64'(q[0].rsv));
      check("bd0", 64'(out_bd[0]), 64'(q[0].br));
    end
    if (ev[1]) begin
      check("pc1", 64'(out_pc[63:32]), 64'(q[1].pc));
      check("instr1", 64'(out_instr[63:32]), 64'(q[1].instr));
      check("rsv1", 64'(out_reserved[1]), 64'(q[1].rsv));
      check("bd1", 64'(out_bd[1]), 64'(q[1].br));
    end
`ifdef DIQ_PERF_EN
    check("perf_dual", 64'(perf_dual), 64'(pd_m));
    check("perf_single", 64'(perf_single), 64'(ps_m));
`endif
  endtask

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic cycle(input bit fl, input bit iv, input int cnt, input int acc);
    logic [1:0] ev_pre;
    int         sz;
    bit         rdy;
    flush      = fl;
    in_valid   = iv;
    in_count   = 2'(cnt);
    in_pc      = lane[0].pc;
    in_data    = {lane[1].instr, lane[0].instr};
    out_accept = 2'(acc);
    ev_pre = exp_valid();
    sz     = q.size();
    rdy    = model_ready();
    @(posedge clk);
`ifdef DIQ_PERF_EN
    if (acc == 2 && pd_m != 32'hFFFF_FFFF) pd_m++;
    if (ev_pre == 2'b01 && sz >= 2 && ps_m != 32'hFFFF_FFFF) ps_m++;
`endif
    if (fl) q.delete();
    else begin
      repeat (acc) void'(q.pop_front());
      if (iv && rdy) for (int k = 0; k < cnt; k++) q.push_back(lane[k]);
    end
    #1;
    compare_all();
  endtask

  task automatic set_beat(input int k0, input int k1);
    lane[0] = make(k0, next_pc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 16'($urandom));
    lane[1] = make(k1, next_pc + 32'd4, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 16'($urandom));
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && q.size() != 0; n++) begin
      logic [1:0] ev;
      ev = exp_valid();
      cycle(0, 0, 1, ev[1] ? 2 : 1);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_count = 2'd1;
    in_pc = '0; in_data = '0; out_accept = '0;
    next_pc = 32'hBFC0_0000;
    lane[0] = make(K_SLL, 32'h0, 5'd0, 5'd0, 5'd0, 16'h0);
    lane[1] = lane[0];
`ifdef DIQ_PERF_EN
    pd_m = 0; ps_m = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    compare_all();

    // Two independent addiu issue together, then both retire.
    lane[0] = make(K_ADDIU, 32'hBFC0_0000, 5'd0, 5'd1, 5'd0, 16'd1);
    lane[1] = make(K_ADDIU, 32'hBFC0_0004, 5'd0, 5'd2, 5'd0, 16'd2);
    cycle(0, 1, 2, 0);
    check("dual_valid", 64'(out_valid), 64'h3);
    check("dual_pc", out_pc, 64'hBFC0_0004_BFC0_0000);
    cycle(0, 0, 1, 2);
    check("dual_drained", 64'(count), 64'd0);

    // Read-after-write keeps the consumer in slot 1 back.
    lane[0] = make(K_ADDIU, 32'hBFC0_0008, 5'd0, 5'd3, 5'd0, 16'd5);
    lane[1] = make(K_ADDU, 32'hBFC0_000C, 5'd3, 5'd3, 5'd4, 16'd0);
    cycle(0, 1, 2, 0);
    check("raw_valid", 64'(out_valid), 64'h1);
    cycle(0, 0, 1, 1);
    check("raw_next", 64'(out_instr[31:0]), 64'(lane[1].instr));
    cycle(0, 0, 1, 1);

    // A branch pairs only with its own delay slot.
    lane[0] = make(K_BEQ, 32'hBFC0_0010, 5'd0, 5'd0, 5'd0, 16'd1);
    lane[1] = make(K_SLL, 32'hBFC0_0014, 5'd0, 5'd0, 5'd0, 16'd0);
    cycle(0, 1, 2, 0);
    check("br_valid", 64'(out_valid), 64'h3);
    check("br_bd", 64'(out_bd), 64'h1);
    cycle(0, 0, 1, 2);
    lane[1] = make(K_BEQ, 32'hBFC0_001C, 5'd0, 5'd0, 5'd0, 16'd1);
    lane[0] = make(K_SLL, 32'hBFC0_0018, 5'd0, 5'd0, 5'd0, 16'd0);
    cycle(0, 1, 2, 0);
    check("br_slot1", 64'(out_valid), 64'h1);
    drain();

    // Fill to DEPTH, reject a push, then free space and straddle the wrap.
    next_pc = 32'h0000_1000;
    for (int b = 0; b < 5; b++) begin
      set_beat(K_LUI, K_LUI);
      cycle(0, 1, 2, 0);
      if (b < 4) next_pc += 32'd8;
    end
    check("full_count", 64'(count), 64'd8);
    check("full_ready", 64'(in_ready), 64'd0);
    cycle(0, 0, 1, 1);
    check("ready_at7", 64'(in_ready), 64'd0);
    cycle(0, 0, 1, 1);
    check("ready_at6", 64'(in_ready), 64'd1);
    set_beat(K_LUI, K_LUI);
    cycle(0, 1, 2, 0);
    next_pc += 32'd8;
    drain();

    // Flush wins over a same-cycle push and accept.
    set_beat(K_ADDIU, K_LUI); cycle(0, 1, 2, 0); next_pc += 32'd8;
    set_beat(K_ADDIU, K_LUI); cycle(0, 1, 2, 0); next_pc += 32'd8;
    set_beat(K_ADDIU, K_LUI); cycle(0, 1, 1, 0); next_pc += 32'd4;
    check("pre_flush", 64'(count), 64'd5);
    set_beat(K_ADDIU, K_LUI);
    cycle(1, 1, 2, 2);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);

    // Reserved and system instructions issue alone.
    lane[0] = make(K_RSV, 32'h0000_2000, 5'd0, 5'd0, 5'd0, 16'd0);
    lane[1] = make(K_ADDIU, 32'h0000_2004, 5'd0, 5'd5, 5'd0, 16'd1);
    cycle(0, 1, 2, 0);
    check("rsv_flag", 64'(out_reserved[0]), 64'd1);
    check("rsv_valid", 64'(out_valid), 64'h1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 1);
    lane[0] = make(K_SYSCALL, 32'h0000_2008, 5'd0, 5'd0, 5'd0, 16'd0);
    lane[1] = make(K_ADDIU, 32'h0000_200C, 5'd0, 5'd6, 5'd0, 16'd1);
    cycle(0, 1, 2, 0);
    check("sys_valid", 64'(out_valid), 64'h1);
    drain();

    // Random traffic with occasional redirects and flushes.
    next_pc = 32'h0040_0000;
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] ev;
      bit         fl, iv;
      int         cnt, acc;
      ev  = exp_valid();
      acc = $urandom_range(0, ev[1] ? 2 : (ev[0] ? 1 : 0));
      fl  = ($urandom_range(0, 99) < 2);
      iv  = ($urandom_range(0, 99) < 70);
      cnt = $urandom_range(1, 2);
      if ($urandom_range(0, 9) == 0) next_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      set_beat($urandom_range(0, NK - 1), $urandom_range(0, NK - 1));
      if (iv && !fl && model_ready()) next_pc += 32'(4 * cnt);
      cycle(fl, iv, cnt, acc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
